urv_mem_model: RTL
==================

// Module: urv_mem_model
// PURPOSE
//  Parametrised bench memory/peripheral model for urv_cpu: unified word RAM serving fetch and data ports.
//  Adds configurable data latency, LFSR-driven fetch stalls, MMIO console/test-done/cycle-counter and a preload port.
//  Replaces ad-hoc testbench memory so ISA and firmware benches share one stall-capable, self-checking model.
// PARAMETERS
//  MEM_WORDS     16384        RAM depth in 32-bit words; power of 2; addresses wrap modulo depth
//  DM_LATENCY    1            cycles from accepted load/store to done pulse; legal 1..15
//  IM_STALL_THR  0            fetch stall threshold 0..255; stall when lfsr[7:0] < IM_STALL_THR (0 = never)
//  LFSR_SEED     16'hACE1     LFSR reset value; nonzero
//  MMIO_BASE     32'h00100000 console TX (+0), test done (+4), cycle counter (+8); all other addresses are RAM
// PORTS
//  clk_i             in   1   clock
//  rst_n_i           in   1   asynchronous active-low reset
//  im_addr_i         in   32  fetch byte address
//  im_data_o         out  32  fetch word
//  im_valid_o        out  1   im_data_o valid for the im_addr_i sampled on the previous edge
//  dm_addr_i         in   32  data byte address
//  dm_data_s_i       in   32  store data
//  dm_data_select_i  in   4   store byte enables
//  dm_store_i        in   1   store request
//  dm_load_i         in   1   load request
//  dm_data_l_o       out  32  load data, valid with dm_load_done_o
//  dm_ready_o        out  1   model idle; requests are accepted only while high
//  dm_load_done_o    out  1   one-cycle load completion
//  dm_store_done_o   out  1   one-cycle store completion
//  ld_we_i           in   1   preload word write
//  ld_addr_i         in   32  preload word index (not byte address)
//  ld_data_i         in   32  preload data
//  con_valid_o       out  1   one-cycle pulse: console byte written
//  con_data_o        out  8   console byte
//  test_done_o       out  1   sticky: test-done register written
//  test_status_o     out  32  value written to test-done register
//  err_o             out  1   sticky protocol error
// BEHAVIOUR
//  Reset values: all outputs 0 except dm_ready_o=1; lfsr=LFSR_SEED; cycle counter=0. RAM contents are not reset.
//  Indexing: word index = addr[log2(MEM_WORDS)+1:2]; upper bits are ignored (wrap).
//  Fetch: each edge, lfsr steps (taps x^16+x^14+x^13+x^11).
//   - No stall: im_data_o <= ram[im_addr_i]; im_valid_o <= 1.
//   - Stall: im_valid_o <= 0; im_data_o holds.
//   - Fetch is independent of the data FSM.
//  Data FSM IDLE/BUSY/DONE; dm_ready_o = (state==IDLE).
//   - IDLE + request: addr, select, data and kind are captured.
//     - RAM store: byte lanes are written on the accept edge.
//     - Counter loaded with DM_LATENCY-1: 0 -> DONE, else -> BUSY.
//   - BUSY: decrement the counter; at 1 -> DONE.
//   - DONE: one-cycle done pulse matching the captured kind, then -> IDLE.
//     - Load data is sampled from RAM/MMIO in DONE, so a store accepted earlier is visible.
//   - DM_LATENCY=1: done is asserted the cycle after accept.
//  MMIO stores (any byte enables) do not touch RAM.
//   - +0: con_data_o <= data[7:0]; con_valid_o pulses on the accept cycle.
//   - +4: test_done_o <= 1; test_status_o <= data.
//   - +8: ignored.
//  MMIO loads: +0 and +4 return 0 and {31'b0,test_done_o}; +8 returns the 32-bit free-running cycle count (wraps).
//  Errors, each setting err_o sticky:
//   - dm_load_i and dm_store_i both high in IDLE: neither is accepted.
//   - Any request while dm_ready_o=0: the request is dropped.
//  Preload: ld_we_i writes ram[ld_addr_i mod MEM_WORDS] full-word any cycle, including while rst_n_i=0.
//   - Same-word collision with an accepted store: preload wins all lanes.
//  Reset asserted mid-transaction: FSM returns to IDLE immediately with no done pulse; RAM is kept.
// STRUCTURE
//  urv_mem_model_pkg: MMIO offset localparams (CON=0, DONE=4, CYC=8), dm_state_t enum {IDLE,BUSY,DONE}, req_kind_t.
//  One sub-module, urv_lfsr16 (clk_i, rst_n_i, seed, state out).
//  RAM is an inferred array with 4 byte-lane write enables plus a full-word preload write.
// TESTING
//  Preload ram[0]=32'h00000013; IM_STALL_THR=0, im_addr_i=0 -> im_valid_o=1 and im_data_o=32'h13 every cycle after reset.
//  IM_STALL_THR=128, 10000 cycles -> im_valid_o low ratio 45-55%; never valid with stale address.
//  DM_LATENCY=3: store 32'hDEADBEEF, sel=4'b0101 @0x40 over old 0 -> store_done 3 cycles later; load -> 32'h00AD00EF.
//  Store 0x41 to 0x100000 then 32'h1 to 0x100004 -> con_valid_o pulse with con_data_o=8'h41, test_done_o=1, status=1, RAM untouched.
//  Load and store asserted together -> err_o=1, no done pulse, dm_ready_o stays 1.
//  Assert rst_n_i during BUSY -> dm_ready_o=1 next edge, no done pulse; subsequent load returns preserved RAM data.

Source files
------------

// File: rtl/urv_mem_model_pkg.sv
// Shared types and MMIO map for the urv_cpu bench memory model.
// The map is relative to the instance's MMIO base; anything that does not decode is RAM.
package urv_mem_model_pkg;

  localparam logic [31:0] MMIO_CON  = 32'h0000_0000;
  localparam logic [31:0] MMIO_DONE = 32'h0000_0004;
  localparam logic [31:0] MMIO_CYC  = 32'h0000_0008;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dm_state_t;
  typedef enum logic {REQ_LOAD, REQ_STORE} req_kind_t;
  typedef enum logic [1:0] {MM_NONE, MM_CON, MM_DONE, MM_CYC} mmio_t;

  // Word-granular decode: the byte offset within a register is ignored.
  function automatic mmio_t mmio_decode(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    if (off[31:2] == MMIO_CON[31:2])  return MM_CON;
    if (off[31:2] == MMIO_DONE[31:2]) return MM_DONE;
    if (off[31:2] == MMIO_CYC[31:2])  return MM_CYC;
    return MM_NONE;
  endfunction

endpackage

// File: rtl/urv_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11, stepping every clock.
// The seed is loaded on reset and must be nonzero.
module urv_lfsr16 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= seed;
    else          state <= {state[14:0], feedback};
  end

endmodule

// File: rtl/urv_mem_model.sv
// Unified fetch/data word RAM for urv_cpu benches: LFSR fetch stalls, fixed data latency,
// console/test-done/cycle-counter MMIO and a preload port that works even under reset.
module urv_mem_model
  import urv_mem_model_pkg::*;
#(
  parameter int          MEM_WORDS    = 16384,
  parameter int          DM_LATENCY   = 1,
  parameter int          IM_STALL_THR = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] MMIO_BASE    = 32'h0010_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_ready_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  output logic        test_done_o,
  output logic [31:0] test_status_o,
  output logic        err_o
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(DM_LATENCY - 1);

  logic [31:0]   ram [MEM_WORDS];
  logic [15:0]   lfsr;
  logic          fetch_stall;
  logic [AW-1:0] im_idx, dm_idx, ld_idx, cap_idx;
  dm_state_t     state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  req_kind_t     cap_kind;
  mmio_t         cap_mmio, req_mmio;
  logic          req_any, accept, store_acc, ram_we;
  logic [31:0]   cyc;
  logic          unused_bits;

  assign im_idx   = im_addr_i[AW+1:2];
  assign dm_idx   = dm_addr_i[AW+1:2];
  assign ld_idx   = ld_addr_i[AW-1:0];
  assign req_mmio = mmio_decode(dm_addr_i, MMIO_BASE);

  // Address bits above the RAM depth simply alias.
  assign unused_bits = ^{im_addr_i[31:AW+2], im_addr_i[1:0], ld_addr_i[31:AW], lfsr[15:8]};

  urv_lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .seed    (LFSR_SEED),
    .state   (lfsr)
  );

  assign fetch_stall = lfsr[7:0] < 8'(IM_STALL_THR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      im_data_o  <= '0;
      im_valid_o <= 1'b0;
    end else if (fetch_stall) begin
      im_valid_o <= 1'b0;
    end else begin
      im_data_o  <= ram[im_idx];
      im_valid_o <= 1'b1;
    end
  end

  assign req_any    = dm_load_i | dm_store_i;
  assign accept     = rst_n_i && (state == IDLE) && (dm_load_i ^ dm_store_i);
  assign store_acc  = accept && dm_store_i;
  assign ram_we     = store_acc && (req_mmio == MM_NONE);
  assign dm_ready_o = (state == IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        cnt_nxt   = LAT_LOAD;
        state_nxt = (LAT_LOAD == 4'd0) ? DONE : BUSY;
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_kind      <= REQ_LOAD;
      cap_idx       <= '0;
      cap_mmio      <= MM_NONE;
      err_o         <= 1'b0;
      con_valid_o   <= 1'b0;
      con_data_o    <= '0;
      test_done_o   <= 1'b0;
      test_status_o <= '0;
      cyc           <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cyc         <= cyc + 32'd1;
      con_valid_o <= store_acc && (req_mmio == MM_CON);
      if (accept) begin
        cap_kind <= dm_store_i ? REQ_STORE : REQ_LOAD;
        cap_idx  <= dm_idx;
        cap_mmio <= req_mmio;
      end
      // Colliding load+store, or anything presented while not ready, is dropped and flagged.
      if (req_any && (state != IDLE || (dm_load_i && dm_store_i))) err_o <= 1'b1;
      if (store_acc && req_mmio == MM_CON) con_data_o <= dm_data_s_i[7:0];
      if (store_acc && req_mmio == MM_DONE) begin
        test_done_o   <= 1'b1;
        test_status_o <= dm_data_s_i;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst_n_i and preload stays live under it.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_data_select_i[b]) ram[dm_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
      end
    end
    // Issued last so a same-word preload overrides every lane of a concurrent store.
    if (ld_we_i) ram[ld_idx] <= ld_data_i;
  end

  assign dm_load_done_o  = (state == DONE) && (cap_kind == REQ_LOAD);
  assign dm_store_done_o = (state == DONE) && (cap_kind == REQ_STORE);

  // Sampled in DONE so stores accepted earlier in the latency window are visible.
  always_comb begin
    dm_data_l_o = '0;
    if (dm_load_done_o) begin
      unique case (cap_mmio)
        MM_CON:  dm_data_l_o = '0;
        MM_DONE: dm_data_l_o = {31'b0, test_done_o};
        MM_CYC:  dm_data_l_o = cyc;
        default: dm_data_l_o = ram[cap_idx];
      endcase
    end
  end

endmodule
